// File: rtl/move_scan_sequencer_pkg.sv
// Shared constants, piece ids and state encoding for the root-level move-scan sequencer.
package move_scan_sequencer_pkg;

    localparam int HEUR_WIDTH  = 10;
    localparam int SCORE_W     = HEUR_WIDTH + 1;
    localparam int NUM_PIECES  = 16;
    localparam int MOVE_W      = 6;
    localparam int GEN_TIMEOUT = 255;
    localparam int CNT_W       = 8;

    localparam logic WHITE = 1'b1;
    localparam logic BLACK = 1'b0;

    // Piece ids for one side, lowest id is scanned first.
    localparam logic [3:0] PIECE_K1 = 4'd0;
    localparam logic [3:0] PIECE_Q1 = 4'd1;
    localparam logic [3:0] PIECE_R1 = 4'd2;
    localparam logic [3:0] PIECE_R2 = 4'd3;
    localparam logic [3:0] PIECE_B1 = 4'd4;
    localparam logic [3:0] PIECE_B2 = 4'd5;
    localparam logic [3:0] PIECE_N1 = 4'd6;
    localparam logic [3:0] PIECE_N2 = 4'd7;
    localparam logic [3:0] PIECE_P8 = 4'd8;
    localparam logic [3:0] PIECE_P7 = 4'd9;
    localparam logic [3:0] PIECE_P6 = 4'd10;
    localparam logic [3:0] PIECE_P5 = 4'd11;
    localparam logic [3:0] PIECE_P4 = 4'd12;
    localparam logic [3:0] PIECE_P3 = 4'd13;
    localparam logic [3:0] PIECE_P2 = 4'd14;
    localparam logic [3:0] PIECE_P1 = 4'd15;

    localparam logic signed [SCORE_W-1:0] SCORE_MIN = 11'b10000000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQUEST,
        ST_WAIT_GEN,
        ST_EVAL,
        ST_NEXT,
        ST_DONE
    } seq_state_t;

    // Strict compare so the first-seen candidate keeps the slot on ties.
    function automatic logic score_beats(input logic signed [SCORE_W-1:0] cand,
                                         input logic signed [SCORE_W-1:0] best);
        return cand > best;
    endfunction

endpackage

// File: rtl/move_scan_sequencer_if.sv
// Control, move-generator and evaluator signals of the move-scan sequencer, bundled as one bus.
interface move_scan_sequencer_if;
    import move_scan_sequencer_pkg::*;

    logic                        en;
    logic                        pl;
    logic [NUM_PIECES-1:0]       alive_vec;
    logic                        gen_req;
    logic [3:0]                  gen_piece;
    logic                        gen_ready;
    logic [MOVE_W-1:0]           gen_move;
    logic                        end_moves;
    logic                        gen_hold;
    logic                        eval_valid;
    logic [3:0]                  eval_piece;
    logic [MOVE_W-1:0]           eval_move;
    logic                        eval_ack;
    logic signed [SCORE_W-1:0]   eval_score;
    logic [3:0]                  best_piece;
    logic [MOVE_W-1:0]           best_move;
    logic signed [SCORE_W-1:0]   best_score;
    logic                        no_move;
    logic                        timeout_err;
    logic                        busy;
    logic                        done;
    logic                        side;

    modport master (
        input  en, pl, alive_vec, gen_ready, gen_move, end_moves, eval_ack, eval_score,
        output gen_req, gen_piece, gen_hold, eval_valid, eval_piece, eval_move,
               best_piece, best_move, best_score, no_move, timeout_err, busy, done, side
    );

    modport slave (
        output en, pl, alive_vec, gen_ready, gen_move, end_moves, eval_ack, eval_score,
        input  gen_req, gen_piece, gen_hold, eval_valid, eval_piece, eval_move,
               best_piece, best_move, best_score, no_move, timeout_err, busy, done, side
    );

endinterface

// File: rtl/move_scan_sequencer_alive_piece_picker.sv
// Priority encoder returning the lowest set bit of the remaining-piece mask.
module move_scan_sequencer_alive_piece_picker
    import move_scan_sequencer_pkg::*;
(
    input  logic [NUM_PIECES-1:0] mask,
    output logic                  found,
    output logic [3:0]            id
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        found = |mask;
        id    = '0;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                id = 4'(i);
            end
        end
    end

endmodule

// File: rtl/move_scan_sequencer.sv
// Root move-search controller: walks alive pieces, streams each candidate to the evaluator
// and keeps the best-scoring (piece, move) for the AI_Engine FSM.
module move_scan_sequencer
    import move_scan_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  RST,
    move_scan_sequencer_if.master bus
);

    seq_state_t                state;
    seq_state_t                next_state;
    logic [NUM_PIECES-1:0]     mask;
    logic [3:0]                cur_id;
    logic [CNT_W-1:0]          wait_cnt;
    logic [MOVE_W-1:0]         cand_move;
    logic                      last_flag;
    logic                      req_pending;
    logic                      cand_seen;
    logic [3:0]                best_piece;
    logic [MOVE_W-1:0]         best_move;
    logic signed [SCORE_W-1:0] best_score;
    logic                      no_move;
    logic                      timeout_err;
    logic                      busy;
    logic                      done;
    logic                      side;
    logic                      pick_found;
    logic [3:0]                pick_id;
    logic                      wait_expired;
    logic                      gen_req;
    logic                      gen_hold;
    logic                      eval_valid;

    move_scan_sequencer_alive_piece_picker u_picker (
        .mask  (mask),
        .found (pick_found),
        .id    (pick_id)
    );

    assign wait_expired = (wait_cnt == CNT_W'(GEN_TIMEOUT));

    always_comb begin
        next_state = state;
        gen_req    = 1'b0;
        gen_hold   = 1'b0;
        eval_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.en) next_state = ST_SELECT;
            end
            ST_SELECT: begin
                next_state = pick_found ? ST_REQUEST : ST_DONE;
            end
            ST_REQUEST: begin
                gen_req    = 1'b1;
                next_state = ST_WAIT_GEN;
            end
            ST_WAIT_GEN: begin
                gen_req = req_pending;
                if (bus.gen_ready) begin
                    next_state = ST_EVAL;
                end else if (bus.end_moves || wait_expired) begin
                    next_state = ST_NEXT;
                end
            end
            ST_EVAL: begin
                gen_hold   = 1'b1;
                eval_valid = 1'b1;
                if (bus.eval_ack) next_state = last_flag ? ST_NEXT : ST_WAIT_GEN;
            end
            ST_NEXT:  next_state = ST_SELECT;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= ST_IDLE;
            mask        <= '0;
            cur_id      <= '0;
            wait_cnt    <= '0;
            cand_move   <= '0;
            last_flag   <= 1'b0;
            req_pending <= 1'b0;
            cand_seen   <= 1'b0;
            best_piece  <= '0;
            best_move   <= '0;
            best_score  <= '0;
            no_move     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            side        <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.en) begin
                        side        <= bus.pl;
                        mask        <= bus.alive_vec;
                        best_score  <= SCORE_MIN;
                        best_piece  <= '0;
                        best_move   <= '0;
                        cand_seen   <= 1'b0;
                        timeout_err <= 1'b0;
                        no_move     <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (pick_found) cur_id <= pick_id;
                end
                ST_REQUEST: begin
                    wait_cnt    <= '0;
                    req_pending <= 1'b1;
                end
                // A response ends the request phase; silence only counts toward abandoning the piece.
                ST_WAIT_GEN: begin
                    if (bus.gen_ready) begin
                        cand_move   <= bus.gen_move;
                        last_flag   <= bus.end_moves;
                        req_pending <= 1'b0;
                    end else if (bus.end_moves) begin
                        req_pending <= 1'b0;
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                        req_pending <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (bus.eval_ack) begin
                        if (score_beats(bus.eval_score, best_score)) begin
                            best_score <= bus.eval_score;
                            best_piece <= cur_id;
                            best_move  <= cand_move;
                        end
                        cand_seen <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end
                ST_NEXT: begin
                    mask[cur_id] <= 1'b0;
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    no_move <= ~cand_seen;
                end
                default: ;
            endcase
        end
    end

    assign bus.gen_req     = gen_req;
    assign bus.gen_piece   = cur_id;
    assign bus.gen_hold    = gen_hold;
    assign bus.eval_valid  = eval_valid;
    assign bus.eval_piece  = cur_id;
    assign bus.eval_move   = cand_move;
    assign bus.best_piece  = best_piece;
    assign bus.best_move   = best_move;
    assign bus.best_score  = best_score;
    assign bus.no_move     = no_move;
    assign bus.timeout_err = timeout_err;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.side        = side;

endmodule

// File: tb/tb_move_scan_sequencer.sv
// Scoreboard bench: generator/evaluator models answer the DUT, a search-level model predicts results.
module tb_move_scan_sequencer;
    import move_scan_sequencer_pkg::*;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    move_scan_sequencer_if bus ();

    move_scan_sequencer dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.master)
    );

    typedef struct {
        logic [3:0]        piece;
        logic [MOVE_W-1:0] move;
    } cand_t;

    typedef struct {
        logic [3:0]        piece;
        logic [MOVE_W-1:0] move;
        int                score;
        bit                no_move;
        bit                timeout;
    } result_t;

    int n_checks = 0;
    int n_pass   = 0;
    int gen_req_cycles = 0;

    int                        n_moves [NUM_PIECES];
    logic [MOVE_W-1:0]         mv      [NUM_PIECES][4];
    bit                        silent  [NUM_PIECES];
    logic signed [SCORE_W-1:0] sc      [NUM_PIECES][64];
    bit                        ack_slow;

    cand_t   cand_q[$];
    result_t res_q[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_tables();
        for (int p = 0; p < NUM_PIECES; p++) begin
            n_moves[p] = 0;
            silent[p]  = 1'b0;
        end
    endtask

    task automatic set_move(input int p, input int k, input int m, input int s);
        mv[p][k]   = MOVE_W'(m);
        sc[p][m]   = SCORE_W'(s);
        if (n_moves[p] < k + 1) n_moves[p] = k + 1;
    endtask

    // Whole-search prediction: every candidate in scan order, best by strict greater-than.
    function automatic void predict(input logic [15:0] alive);
        result_t r;
        r.score   = -1023;
        r.piece   = '0;
        r.move    = '0;
        r.no_move = 1'b1;
        r.timeout = 1'b0;
        for (int p = 0; p < NUM_PIECES; p++) begin
            if (alive[p]) begin
                if (silent[p]) begin
                    r.timeout = 1'b1;
                end else begin
                    for (int k = 0; k < n_moves[p]; k++) begin
                        cand_q.push_back('{4'(p), mv[p][k]});
                        if (int'(sc[p][mv[p][k]]) > r.score) begin
                            r.score = int'(sc[p][mv[p][k]]);
                            r.piece = 4'(p);
                            r.move  = mv[p][k];
                        end
                        r.no_move = 1'b0;
                    end
                end
            end
        end
        res_q.push_back(r);
    endfunction

    always @(negedge clk) begin
        if (bus.gen_req === 1'b1) gen_req_cycles++;
    end

    // Move generator: answers each request with the table's moves, respecting gen_hold.
    typedef enum {G_IDLE, G_DELAY, G_HOLD, G_SILENT} gen_st_t;
    gen_st_t    g_st;
    int         g_delay;
    int         g_k;
    logic [3:0] g_p;

    always @(negedge clk) begin
        bus.gen_ready = 1'b0;
        bus.end_moves = 1'b0;
        if (RST) begin
            g_st         = G_IDLE;
            bus.gen_move = '0;
        end else begin
            case (g_st)
                G_IDLE: begin
                    if (bus.gen_req === 1'b1) begin
                        g_p = bus.gen_piece;
                        g_k = 0;
                        if (silent[g_p]) begin
                            g_st = G_SILENT;
                        end else begin
                            g_delay = int'($urandom_range(1, 3));
                            g_st    = G_DELAY;
                        end
                    end
                end
                G_DELAY: begin
                    g_delay--;
                    if (g_delay == 0) begin
                        if (n_moves[g_p] == 0) begin
                            bus.end_moves = 1'b1;
                            g_st          = G_IDLE;
                        end else begin
                            bus.gen_ready = 1'b1;
                            bus.gen_move  = mv[g_p][g_k];
                            bus.end_moves = (g_k == n_moves[g_p] - 1);
                            g_k++;
                            g_st = bus.end_moves ? G_IDLE : G_HOLD;
                        end
                    end
                end
                G_HOLD: begin
                    if (bus.gen_hold === 1'b0) begin
                        g_delay = int'($urandom_range(1, 2));
                        g_st    = G_DELAY;
                    end
                end
                G_SILENT: begin
                    if (bus.gen_req === 1'b0) g_st = G_IDLE;
                end
                default: g_st = G_IDLE;
            endcase
        end
    end

    // Evaluator and candidate monitor: pops the expected candidate and checks it stays stable until ack.
    typedef enum {E_IDLE, E_WAIT} eval_st_t;
    eval_st_t          e_st;
    int                e_delay;
    logic [3:0]        e_p;
    logic [MOVE_W-1:0] e_m;

    always @(negedge clk) begin
        cand_t c;
        bus.eval_ack = 1'b0;
        if (RST) begin
            e_st           = E_IDLE;
            bus.eval_score = '0;
        end else begin
            case (e_st)
                E_IDLE: begin
                    if (bus.eval_valid === 1'b1) begin
                        check_output("cand_pending", 32'(cand_q.size() != 0), 1);
                        if (cand_q.size() != 0) begin
                            c = cand_q.pop_front();
                            check_output("cand_piece", 32'(bus.eval_piece), 32'(c.piece));
                            check_output("cand_move", 32'(bus.eval_move), 32'(c.move));
                        end
                        e_p     = bus.eval_piece;
                        e_m     = bus.eval_move;
                        e_delay = ack_slow ? 10 : int'($urandom_range(0, 3));
                        if (e_delay == 0) begin
                            bus.eval_ack   = 1'b1;
                            bus.eval_score = sc[e_p][e_m];
                        end else begin
                            e_st = E_WAIT;
                        end
                    end
                end
                E_WAIT: begin
                    check_output("hold_valid", 32'(bus.eval_valid), 1);
                    check_output("hold_piece", 32'(bus.eval_piece), 32'(e_p));
                    check_output("hold_move", 32'(bus.eval_move), 32'(e_m));
                    check_output("hold_gen_hold", 32'(bus.gen_hold), 1);
                    e_delay--;
                    if (e_delay == 0) begin
                        bus.eval_ack   = 1'b1;
                        bus.eval_score = sc[e_p][e_m];
                        e_st           = E_IDLE;
                    end
                end
                default: e_st = E_IDLE;
            endcase
        end
    end

    // Result monitor: every done pulse must match the next predicted search result.
    always @(negedge clk) begin
        result_t r;
        if (RST === 1'b0 && bus.done === 1'b1) begin
            check_output("result_pending", 32'(res_q.size() != 0), 1);
            if (res_q.size() != 0) begin
                r = res_q.pop_front();
                check_output("best_piece", 32'(bus.best_piece), 32'(r.piece));
                check_output("best_move", 32'(bus.best_move), 32'(r.move));
                check_output("best_score", 32'(bus.best_score), 32'(r.score));
                check_output("no_move", 32'(bus.no_move), 32'(r.no_move));
                check_output("timeout_err", 32'(bus.timeout_err), 32'(r.timeout));
            end
        end
    end

    task automatic apply_stimulus(input logic [15:0] alive, input bit mid_en);
        int   cyc;
        int   req_before;
        logic side_bit;
        predict(alive);
        req_before = gen_req_cycles;
        side_bit   = 1'($urandom);
        @(negedge clk);
        bus.alive_vec = alive;
        bus.pl        = side_bit;
        bus.en        = 1'b1;
        @(negedge clk);
        bus.en        = 1'b0;
        bus.alive_vec = 16'($urandom);
        bus.pl        = ~side_bit;
        check_output("busy_after_en", 32'(bus.busy), 1);
        check_output("side_latched", 32'(bus.side), 32'(side_bit));
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            bus.en = mid_en && (bus.done !== 1'b1) && (cyc == 6 || cyc == 30);
        end
        bus.en = 1'b0;
        check_output("done_seen", 32'(bus.done), 1);
        if (alive == 16'h0000) begin
            check_output("empty_latency", 32'(cyc), 3);
            check_output("empty_no_req", 32'(gen_req_cycles - req_before), 0);
        end
        check_output("cands_consumed", 32'(cand_q.size()), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] alive;
        int          n;
        int          base;
        int          cyc;
        RST           = 1'b1;
        bus.en        = 1'b0;
        bus.pl        = 1'b0;
        bus.alive_vec = '0;
        ack_slow      = 1'b0;
        clear_tables();
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(bus.busy), 0);
        check_output("rst_done", 32'(bus.done), 0);
        check_output("rst_gen_req", 32'(bus.gen_req), 0);
        check_output("rst_gen_hold", 32'(bus.gen_hold), 0);
        check_output("rst_eval_valid", 32'(bus.eval_valid), 0);
        check_output("rst_best_piece", 32'(bus.best_piece), 0);
        check_output("rst_best_move", 32'(bus.best_move), 0);
        check_output("rst_best_score", 32'(bus.best_score), 0);
        check_output("rst_no_move", 32'(bus.no_move), 0);
        check_output("rst_timeout_err", 32'(bus.timeout_err), 0);
        RST = 1'b0;

        clear_tables();
        apply_stimulus(16'h0000, 1'b0);

        clear_tables();
        set_move(0, 0, 5, 20);
        set_move(0, 1, 9, 40);
        apply_stimulus(16'h0001, 1'b0);

        clear_tables();
        set_move(1, 0, 3, 7);
        set_move(2, 0, 4, 7);
        apply_stimulus(16'h0006, 1'b0);

        clear_tables();
        silent[0] = 1'b1;
        set_move(1, 0, 12, -5);
        apply_stimulus(16'h0003, 1'b0);

        clear_tables();
        set_move(0, 0, 1, 100);
        set_move(0, 1, 2, -50);
        set_move(4, 0, 33, 200);
        set_move(4, 1, 34, 200);
        ack_slow = 1'b1;
        apply_stimulus(16'h0011, 1'b1);
        ack_slow = 1'b0;

        // Abort a search while a candidate is with the evaluator, then rerun it cleanly.
        clear_tables();
        set_move(0, 0, 5, 20);
        set_move(0, 1, 9, 40);
        ack_slow = 1'b1;
        predict(16'h0001);
        @(negedge clk);
        bus.alive_vec = 16'h0001;
        bus.en        = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        cyc    = 0;
        while (bus.eval_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_output("eval_reached", 32'(bus.eval_valid), 1);
        RST = 1'b1;
        @(negedge clk);
        check_output("abort_busy", 32'(bus.busy), 0);
        check_output("abort_done", 32'(bus.done), 0);
        check_output("abort_eval_valid", 32'(bus.eval_valid), 0);
        check_output("abort_best_piece", 32'(bus.best_piece), 0);
        check_output("abort_best_move", 32'(bus.best_move), 0);
        check_output("abort_best_score", 32'(bus.best_score), 0);
        cand_q.delete();
        res_q.delete();
        @(negedge clk);
        RST      = 1'b0;
        ack_slow = 1'b0;
        apply_stimulus(16'h0001, 1'b0);

        for (int it = 0; it < 40; it++) begin
            clear_tables();
            alive = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            for (int p = 0; p < NUM_PIECES; p++) begin
                n    = int'($urandom_range(0, 3));
                base = int'($urandom_range(0, 63));
                for (int k = 0; k < n; k++) begin
                    set_move(p, k, (base + 7 * k) % 64,
                             ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 2047)) - 1024);
                end
            end
            if ($urandom_range(0, 3) == 0) silent[$urandom_range(0, 15)] = 1'b1;
            apply_stimulus(alive, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check_output("cand_q_empty", 32'(cand_q.size()), 0);
        check_output("res_q_empty", 32'(res_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
